// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared funct3 codes, state encodings and width codes
package mem_access_stage_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] WIDTH_B = 2'd0;
  localparam logic [1:0] WIDTH_H = 2'd1;
  localparam logic [1:0] WIDTH_W = 2'd2;

  // Unlisted funct3 values fall back to a full word access.
  function automatic logic [1:0] width_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   width_of = WIDTH_B;
      2'b01:   width_of = WIDTH_H;
      default: width_of = WIDTH_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_fmt.sv
// rtl/mem_access_stage_lane_fmt.sv - store lane steering/strobes and load extraction/extension
module mem_access_stage_lane_fmt
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_word;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (width_of(st_funct3))
      WIDTH_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_lane;
      end
      WIDTH_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = st_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Rotating the word brings the addressed lane to bit 0; a half at lane 3 wraps onto lane 0.
  always_comb begin
    ld_word = 32'({ld_rdata, ld_rdata} >> {ld_lane, 3'b000});
    case (width_of(ld_funct3))
      WIDTH_B: ld_data = ld_funct3[2] ? {24'd0, ld_word[7:0]}
                                      : {{24{ld_word[7]}}, ld_word[7:0]};
      WIDTH_H: ld_data = ld_funct3[2] ? {16'd0, ld_word[15:0]}
                                      : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory-access stage; optional MEM_ACCESS_MISALIGN_CHECK_EN adds misaligned output
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] rd_mem_addr,
  input  logic [ADDR_W-1:0] wr_mem_addr,
  input  logic [31:0]       wr_mem_data,
  input  logic [2:0]        funct3,
  input  logic [31:0]       result,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              busy,
  output logic              bus_err
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] cap_addr;
  logic              is_mem;
  logic              timeout_hit;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_data;

  // Stores win when both request flags are set.
  assign cap_addr    = wr_mem ? wr_mem_addr : rd_mem_addr;
  assign is_mem      = rd_mem | wr_mem;
  assign timeout_hit = (ACK_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= ACK_TIMEOUT);
  assign busy        = (state_q != ST_IDLE);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic mis_req;
  assign mis_req = ((width_of(funct3) == WIDTH_H) && cap_addr[0]) ||
                   ((width_of(funct3) == WIDTH_W) && (cap_addr[1:0] != 2'b00));
`endif

  mem_access_stage_lane_fmt u_lane_fmt (
    .st_funct3 (funct3),
    .st_lane   (cap_addr[1:0]),
    .st_data   (wr_mem_data),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (funct3_q),
    .ld_lane   (lane_q),
    .ld_rdata  (bus_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= 32'd0;
      bus_wstrb  <= 4'd0;
      wb_data    <= 32'd0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            funct3_q <= funct3;
            lane_q   <= cap_addr[1:0];
            bus_err  <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
            if (!is_mem) begin
              wb_data <= result;
              done    <= 1'b1;
              state_q <= ST_RESP;
            end
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            else if (mis_req) begin
              misaligned <= 1'b1;
              wb_data    <= 32'd0;
              done       <= 1'b1;
              state_q    <= ST_RESP;
            end
`endif
            else begin
              bus_req   <= 1'b1;
              bus_we    <= wr_mem;
              bus_addr  <= {cap_addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= wr_mem ? st_wdata : 32'd0;
              bus_wstrb <= wr_mem ? st_wstrb : 4'd0;
              cnt_q     <= '0;
              state_q   <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            wb_data <= bus_we ? 32'd0 : ld_data;
            done    <= 1'b1;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            wb_data <= 32'd0;
            done    <= 1'b1;
            state_q <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        rd_mem = 1'b0;
  logic        wr_mem = 1'b0;
  logic [31:0] rd_mem_addr = '0;
  logic [31:0] wr_mem_addr = '0;
  logic [31:0] wr_mem_data = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] result = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] wb_data;
  logic        done;
  logic        busy;
  logic        bus_err;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.ACK_TIMEOUT(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .rd_mem_addr (rd_mem_addr),
    .wr_mem_addr (wr_mem_addr),
    .wr_mem_data (wr_mem_data),
    .funct3      (funct3),
    .result      (result),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .wb_data     (wb_data),
    .done        (done),
    .busy        (busy),
    .bus_err     (bus_err)
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] raddr,
                       input logic [31:0] waddr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] res);
    rd_mem = rd; wr_mem = wr; rd_mem_addr = raddr; wr_mem_addr = waddr;
    wr_mem_data = wdata; funct3 = f3; result = res; req = 1'b1;
    tick();
    req = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0;
  endtask

  task automatic load_ack(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wb);
    issue(1'b1, 1'b0, addr, 32'h0, 32'h0, f3, 32'h0);
    chk({tag, "_bus_req"}, bus_req, 1);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_wstrb"}, bus_wstrb, 0);
    bus_ack = 1'b1; bus_rdata = rdata;
    tick();
    bus_ack = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wb"}, wb_data, exp_wb);
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_err", bus_err, 0);
    reset = 1'b1;
    tick();

    // Pass-through
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h1234_5678);
    chk("pt_done", done, 1);
    chk("pt_wb", wb_data, 32'h1234_5678);
    chk("pt_bus_req", bus_req, 0);
    chk("pt_busy", busy, 1);
    tick();
    chk("pt_done_pulse", done, 0);
    chk("pt_idle", busy, 0);

    // Loads, ack in the first BUS cycle
    load_ack("lb",  32'h103, 3'b000, 32'h80AA_BBCC, 32'h100, 32'hFFFF_FF80);
    load_ack("lbu", 32'h103, 3'b100, 32'h80AA_BBCC, 32'h100, 32'h0000_0080);
    load_ack("lh",  32'h102, 3'b001, 32'h80AA_BBCC, 32'h100, 32'hFFFF_80AA);
    load_ack("lhu", 32'h100, 3'b101, 32'h80AA_BBCC, 32'h100, 32'h0000_BBCC);
    load_ack("lw",  32'h104, 3'b010, 32'h80AA_BBCC, 32'h104, 32'h80AA_BBCC);
    load_ack("f3_11", 32'h108, 3'b011, 32'h1357_9BDF, 32'h108, 32'h1357_9BDF);
    load_ack("lb1", 32'h101, 3'b000, 32'h0000_7F00, 32'h100, 32'h0000_007F);
`ifndef MEM_ACCESS_MISALIGN_CHECK_EN
    load_ack("lh_wrap", 32'h103, 3'b001, 32'h80AA_BBCC, 32'h100, 32'hFFFF_CC80);
`endif

    // SH at 0x202 with a one-cycle ack delay and a stray req while busy
    issue(1'b0, 1'b1, 32'h0, 32'h202, 32'h0000_BEEF, 3'b001, 32'hDEAD_DEAD);
    chk("sh_we", bus_we, 1);
    chk("sh_addr", bus_addr, 32'h200);
    chk("sh_wstrb", bus_wstrb, 4'b1100);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    req = 1'b1; result = 32'h5555_5555;
    tick();
    req = 1'b0;
    chk("sh_wait_req", bus_req, 1);
    chk("sh_wait_done", done, 0);
    chk("sh_stable_addr", bus_addr, 32'h200);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sh_done", done, 1);
    chk("sh_wb", wb_data, 0);
    tick();
    chk("sh_idle", busy, 0);

    // SB at lane 1
    issue(1'b0, 1'b1, 32'h0, 32'h301, 32'h1234_5678, 3'b000, 32'h0);
    chk("sb_wstrb", bus_wstrb, 4'b0010);
    chk("sb_wdata", bus_wdata, 32'h7878_7878);
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    chk("sb_done", done, 1);
    tick();

    // rd_mem and wr_mem both set: store wins
    issue(1'b1, 1'b1, 32'h20, 32'h10, 32'hCAFE_F00D, 3'b010, 32'h0);
    chk("both_we", bus_we, 1);
    chk("both_addr", bus_addr, 32'h10);
    chk("both_wstrb", bus_wstrb, 4'b1111);
    chk("both_wdata", bus_wdata, 32'hCAFE_F00D);
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    chk("both_done", done, 1);
    chk("both_wb", wb_data, 0);
    tick();

    // Timeout with no ack: bus_req held for 4 cycles
    issue(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 3'b010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), bus_req, 1);
      chk($sformatf("to_nodone_%0d", i), done, 0);
      tick();
    end
    chk("to_done", done, 1);
    chk("to_err", bus_err, 1);
    chk("to_wb", wb_data, 0);
    chk("to_bus_req", bus_req, 0);
    tick();

    // Ack on the timeout cycle wins
    issue(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 3'b010, 32'h0);
    tick(); tick(); tick();
    chk("edge_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0;
    chk("edge_done", done, 1);
    chk("edge_err", bus_err, 0);
    chk("edge_wb", wb_data, 32'h1122_3344);
    tick();

    // Asynchronous reset mid-BUS, then a late ack
    issue(1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 3'b010, 32'h0);
    chk("mid_req", bus_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_req_drop", bus_req, 0);
    chk("mid_busy", busy, 0);
    tick();
    reset = 1'b1;
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("late_ack_done", done, 0);
    tick();
    chk("late_ack_done2", done, 0);
    chk("late_ack_busy", busy, 0);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 3'b010, 32'h0);
    chk("mis_done", done, 1);
    chk("mis_flag", misaligned, 1);
    chk("mis_wb", wb_data, 0);
    chk("mis_bus_req", bus_req, 0);
    tick();
    load_ack("al_lw", 32'h14, 3'b010, 32'hA5A5_5A5A, 32'h14, 32'hA5A5_5A5A);
    chk("al_flag", misaligned, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RV32I pipeline; sits between the execute stage and register writeback.
- Consumes the execute stage's memory request (rd_mem/wr_mem, addresses, store data) plus funct3.
- Runs a req/ack transaction on the data-memory bus, including byte-lane steering, write strobes and load sign/zero extension.
- Returns the writeback value with a one-cycle done pulse; non-memory instructions pass result straight through.

Parameters:
- ACK_TIMEOUT, 255: max cycles bus_req may wait for bus_ack before abort; 0 disables the timeout.
- ADDR_W, 32: address width of exec inputs and bus.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  start strobe; inputs below valid this cycle only
- rd_mem  in  1  load request
- wr_mem  in  1  store request
- rd_mem_addr  in  ADDR_W  load byte address
- wr_mem_addr  in  ADDR_W  store byte address
- wr_mem_data  in  32  store data, taken from rrs2 in the exec stage
- funct3  in  3  access width/sign
- result  in  32  exec result for non-memory instructions
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address, low 2 bits forced to 0
- bus_wdata  out  32  lane-steered store data
- bus_wstrb  out  4  byte enables, 0 on reads
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completes the transaction
- wb_data  out  32  writeback value, valid while done=1
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- bus_err  out  1  timeout flag, valid while done=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - wb_data=0, done=0, busy=0, bus_err=0, timeout counter=0.
  - Applies mid-transaction too: bus_req drops immediately and any later bus_ack is ignored.
- Request capture and priority:
  - req is sampled only in IDLE; req in any other state is ignored.
  - All inputs are registered on capture.
  - wr_mem has priority if rd_mem and wr_mem are both high; the store is performed.
- States:
  - IDLE:
    - req with neither rd_mem nor wr_mem -> RESP, wb_data=result.
    - req with rd_mem or wr_mem -> BUS.
  - BUS:
    - bus_req=1; bus signals stay stable until ack.
    - bus_ack -> RESP; load data is formatted from bus_rdata in the ack cycle.
    - Counter reaches ACK_TIMEOUT before ack -> RESP with bus_err=1 and wb_data=0.
    - bus_ack in the same cycle as the timeout: the ack wins, no error.
  - RESP: done=1 for exactly one cycle -> IDLE.
- Latency (req to done):
  - Pass-through: 1 cycle.
  - Memory access: 2 cycles + ack wait, i.e. done is 2 cycles after req when ack arrives in the first BUS cycle.
- Stores, lane = addr[1:0]:
  - SB (000): wstrb=0001<<lane; wdata=byte replicated to all 4 lanes.
  - SH (001): wstrb=0011<<(lane[1]*2); half replicated to both halves.
  - SW (010): wstrb=1111.
  - wb_data=0 for stores; the downstream writeback enable already suppresses the register write.
- Loads: select the byte or half at lane from bus_rdata.
  - LB 000, LH 001: sign-extend.
  - LBU 100, LHU 101: zero-extend.
  - LW 010: full word.
  - Any other funct3: treated as LW.
- Timeout counter: cleared on entry to BUS, saturating, not used when ACK_TIMEOUT=0.
- Little-endian throughout.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit), valid while done=1.
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, skips BUS entirely: IDLE -> RESP, misaligned=1, wb_data=0, no bus_req.
- Undefined:
  - No port.
  - Low address bits used only for lane selection; a misaligned half at lane 3 wraps to lanes 3/0 within the same word, with no second access.

Decomposition:
- Shared package/header mem_access.hv holds the constants:
  - funct3 load/store codes FUNCT3_LB..FUNCT3_LHU and FUNCT3_SB..FUNCT3_SW.
  - State encodings ST_IDLE, ST_BUS, ST_RESP.
  - Width codes.
- Natural sub-module: lane_fmt, purely combinational.
  - Store side: wdata steering and wstrb generation.
  - Load side: extraction and sign/zero extension.

Test Plan:
- Pass-through: req, rd_mem=wr_mem=0, result=0x1234_5678 -> next cycle done=1, wb_data=0x1234_5678, bus_req never asserted.
- LB sign-extend: rd_mem_addr=0x103, funct3=000; ack one cycle after bus_req with rdata=0x80AA_BBCC -> bus_addr=0x100, wb_data=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x202, data 0x0000_BEEF -> bus_we=1, bus_addr=0x200, wstrb=1100, wdata=0xBEEF_BEEF; done 1 cycle after ack, wb_data=0.
- Timeout: ACK_TIMEOUT=4, no ack -> bus_req high 4 cycles, then done=1, bus_err=1, bus_req=0.
- Reset mid-BUS: reset=0 while bus_req=1 -> bus_req=0 immediately; after release, a late bus_ack causes no done.
- Both rd_mem and wr_mem high at 0x10, SW -> store issued, wstrb=1111; with MEM_ACCESS_MISALIGN_CHECK_EN, LW at 0x11 -> misaligned=1, no bus_req.
